// File: rtl/iic_pkg.sv
// Shared definitions for the AHB-lite I2C master: register map, CMD/STATUS bit
// positions and the bus-sequencer state encoding.
package iic_pkg;
  localparam logic [1:0] ADDR_CMD      = 2'd0;
  localparam logic [1:0] ADDR_TXDATA   = 2'd1;
  localparam logic [1:0] ADDR_STATUS   = 2'd2;
  localparam logic [1:0] ADDR_PRESCALE = 2'd3;

  localparam int CMD_START  = 0;
  localparam int CMD_STOP   = 1;
  localparam int CMD_WRITE  = 2;
  localparam int CMD_READ   = 3;
  localparam int CMD_ACKOUT = 4;

  localparam int ST_BUSY  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_RXACK = 2;
  localparam int ST_ARB   = 3;
  localparam int ST_IRQ   = 4;

  typedef enum logic [2:0] {S_IDLE, S_START, S_BITS, S_ACK, S_STOP} state_t;
endpackage

// File: rtl/iic_tick_gen.sv
// Quarter-bit tick generator: one pulse every prescale+1 cycles while enabled.
// The divisor is sampled only on reload so mid-transfer writes wait their turn.
module iic_tick_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] prescale,
  output logic        tick
);
  logic [15:0] cnt;

  assign tick = enable && (cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (rst || !enable) cnt <= '0;
    else if (cnt == 16'd0) cnt <= prescale;
    else cnt <= cnt - 16'd1;
  end
endmodule

// File: rtl/ahblite_iic_master.sv
// AHB-lite register front end and I2C bus sequencer (START/BITS/ACK/STOP).
// Define IIC_IRQ_EN to add the IRQ_PEND latch and the IIC_IRQ output.
module ahblite_iic_master
  import iic_pkg::*;
#(
  parameter logic [15:0] PRESCALE_RST = 16'd124
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        IIC_SCL,
  inout  wire         IIC_SDA
`ifdef IIC_IRQ_EN
  ,
  output logic        IIC_IRQ
`endif
);
  logic [1:0]  addr_q;
  logic        wr_q;
  logic [7:0]  txdata;
  logic [15:0] prescale;

  state_t      state, state_n;
  logic [1:0]  q, q_n;
  logic [2:0]  bitn, bitn_n;
  logic        scl, scl_n, oe, oe_n;
  logic [7:0]  shreg, shreg_n, rxdata, rxdata_n;
  logic [4:0]  flags, flags_n;
  logic        busy, busy_n, done, done_n, rxack, rxack_n;
  logic        arb, arb_n, irq_pend, irq_n;
  logic        rd, xfer, cmd_acc, tick, sda_in;
  logic        unused;

  assign unused    = ^{HADDR[31:4], HADDR[1:0], HSIZE, HPROT, HWDATA[31:16]};
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign IIC_SCL   = scl;
  assign IIC_SDA   = oe ? 1'b0 : 1'bz;
  assign sda_in    = IIC_SDA;
`ifdef IIC_IRQ_EN
  assign IIC_IRQ   = irq_pend;
`endif

  assign rd      = flags[CMD_READ] & ~flags[CMD_WRITE];
  assign xfer    = flags[CMD_READ] | flags[CMD_WRITE];
  assign cmd_acc = wr_q && (addr_q == ADDR_CMD) && !busy;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q   <= '0;
      wr_q     <= 1'b0;
      txdata   <= '0;
      prescale <= PRESCALE_RST;
    end else begin
      wr_q <= HSEL & HREADY & HTRANS[1] & HWRITE;
      if (HSEL & HREADY & HTRANS[1]) addr_q <= HADDR[3:2];
      if (wr_q && addr_q == ADDR_TXDATA)   txdata   <= HWDATA[7:0];
      if (wr_q && addr_q == ADDR_PRESCALE) prescale <= HWDATA[15:0];
    end
  end

  always_comb begin
    HRDATA = '0;
    case (addr_q)
      ADDR_TXDATA:   HRDATA[7:0]  = txdata;
      ADDR_STATUS:   HRDATA[15:0] = {rxdata, 3'b000, irq_pend, arb, rxack, done, busy};
      ADDR_PRESCALE: HRDATA[15:0] = prescale;
      default: ;
    endcase
  end

  iic_tick_gen u_tick (
    .clk(HCLK), .rst(HRESET), .enable(busy), .prescale(prescale), .tick(tick)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= S_IDLE; q <= '0; bitn <= '0; scl <= 1'b1; oe <= 1'b0;
      shreg <= '0; rxdata <= '0; flags <= '0; busy <= 1'b0; done <= 1'b0;
      rxack <= 1'b0; arb <= 1'b0; irq_pend <= 1'b0;
    end else begin
      state <= state_n; q <= q_n; bitn <= bitn_n; scl <= scl_n; oe <= oe_n;
      shreg <= shreg_n; rxdata <= rxdata_n; flags <= flags_n; busy <= busy_n;
      done <= done_n; rxack <= rxack_n; arb <= arb_n; irq_pend <= irq_n;
    end
  end

  // Each tick performs the action of the current quarter, then advances it.
  always_comb begin
    state_n = state; q_n = q; bitn_n = bitn; scl_n = scl; oe_n = oe;
    shreg_n = shreg; rxdata_n = rxdata; flags_n = flags; busy_n = busy;
    done_n = done; rxack_n = rxack; arb_n = arb; irq_n = irq_pend;
    if (cmd_acc) begin
      arb_n = 1'b0;
      if (|HWDATA[3:0]) begin
        flags_n = HWDATA[4:0];
        done_n  = 1'b0;
        busy_n  = 1'b1;
        q_n     = '0;
        bitn_n  = '0;
        shreg_n = txdata;
        state_n = HWDATA[CMD_START] ? S_START :
                  (HWDATA[CMD_WRITE] | HWDATA[CMD_READ]) ? S_BITS : S_STOP;
      end
    end else if (tick && state != S_IDLE) begin
      q_n = q + 2'd1;
      // Released SDA seen low with SCL high: another master owns the bus.
      if (scl && !oe && !sda_in && state != S_ACK && !(state == S_BITS && rd)) begin
        arb_n = 1'b1; state_n = S_IDLE; oe_n = 1'b0; scl_n = 1'b1; busy_n = 1'b0; q_n = '0;
      end else begin
        case (state)
          S_START:
            case (q)
              2'd0: oe_n  = 1'b0;
              2'd1: scl_n = 1'b1;
              2'd2: oe_n  = 1'b1;
              default: begin
                scl_n   = 1'b0;
                state_n = xfer ? S_BITS : (flags[CMD_STOP] ? S_STOP : S_IDLE);
              end
            endcase
          S_BITS:
            case (q)
              2'd0: oe_n  = rd ? 1'b0 : ~shreg[7];
              2'd1: scl_n = 1'b1;
              2'd2: if (rd) shreg_n = {shreg[6:0], sda_in};
              default: begin
                scl_n = 1'b0;
                if (!rd) shreg_n = {shreg[6:0], 1'b0};
                bitn_n = bitn + 3'd1;
                if (bitn == 3'd7) state_n = S_ACK;
              end
            endcase
          S_ACK:
            case (q)
              2'd0: oe_n  = rd ? ~flags[CMD_ACKOUT] : 1'b0;
              2'd1: scl_n = 1'b1;
              2'd2: if (rd) rxdata_n = shreg; else rxack_n = sda_in;
              default: begin
                scl_n   = 1'b0;
                state_n = flags[CMD_STOP] ? S_STOP : S_IDLE;
              end
            endcase
          S_STOP:
            case (q)
              2'd0: oe_n  = 1'b1;
              2'd1: scl_n = 1'b1;
              2'd2: oe_n  = 1'b0;
              default: state_n = S_IDLE;
            endcase
          default: ;
        endcase
        if (q == 2'd3 && state_n == S_IDLE) begin
          busy_n = 1'b0;
          done_n = 1'b1;
        end
      end
    end
`ifdef IIC_IRQ_EN
    if (wr_q && addr_q == ADDR_STATUS && HWDATA[ST_IRQ]) irq_n = 1'b0;
    if ((done_n && !done) || (arb_n && !arb)) irq_n = 1'b1;
`endif
  end
endmodule

// File: tb/tb_ahblite_iic_master.sv
// Directed bench for ahblite_iic_master: AHB register access plus a small
// I2C slave that acks writes, sources read bytes and can clamp SDA low.
module tb_ahblite_iic_master;
  logic        HCLK, HRESET, HSEL, HWRITE, HREADY;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HREADYOUT, HRESP, IIC_SCL;
  logic [31:0] HRDATA;
  wire         sda;
`ifdef IIC_IRQ_EN
  logic        IIC_IRQ;
`endif

  localparam logic [31:0] NOIRQ = 32'hFFFF_FFEF;

  int errors = 0, checks = 0;
  int nfall = 0, nrise = 0, starts = 0, stops = 0, base = 1000, idx;
  logic        slv_low, slv_tx_en = 1'b0, slv_ack_en = 1'b0, force_low = 1'b0;
  logic [7:0]  slv_byte = 8'h00;
  logic [15:0] cap = '0;
  time         t_last = 0, t_prev = 0;

  ahblite_iic_master dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
    .IIC_SCL(IIC_SCL), .IIC_SDA(sda)
`ifdef IIC_IRQ_EN
    , .IIC_IRQ(IIC_IRQ)
`endif
  );

  pullup (sda);
  assign sda = slv_low ? 1'b0 : 1'bz;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Slave bit slot = SCL falls since the armed base; data changes only on SCL falls.
  always_comb begin
    idx = nfall - base;
    slv_low = 1'b0;
    if (slv_tx_en && idx >= 0 && idx < 8) slv_low = ~slv_byte[3'(7 - idx)];
    if (slv_ack_en && idx == 8) slv_low = 1'b1;
    if (force_low) slv_low = 1'b1;
  end

  always @(negedge IIC_SCL) nfall++;
  always @(posedge IIC_SCL) begin
    cap = {cap[14:0], sda};
    nrise++;
    t_prev = t_last;
    t_last = $time;
  end
  always @(negedge sda) if (IIC_SCL === 1'b1) starts++;
  always @(posedge sda) if (IIC_SCL === 1'b1) stops++;

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(posedge HCLK);
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  task automatic wait_idle(output bit ok);
    logic [31:0] d;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      ahb_read(32'h8, d);
      if (d[0] == 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    HRESET = 1'b1;
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    checks++; if (IIC_SCL !== 1'b1) begin errors++; $display("FAIL reset_scl: got %b want 1", IIC_SCL); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b want 1", sda); end
    ahb_read(32'h8, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 00000000", d); end
    ahb_read(32'hC, d);
    checks++; if (d !== 32'd124) begin errors++; $display("FAIL reset_prescale: got %0d want 124", d); end
    ahb_read(32'h4, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_txdata: got %h want 0", d); end
  endtask

  task automatic test_write();
    logic [31:0] d; bit ok; int s0;
    ahb_write(32'hC, 32'd3);
    ahb_write(32'h4, 32'hA5);
    slv_tx_en = 1'b0; slv_ack_en = 1'b1; base = nfall + 1; s0 = starts;
    ahb_write(32'h0, 32'h05);
    ahb_read(32'h8, d);
    checks++; if (d[0] !== 1'b1) begin errors++; $display("FAIL write_busy_set: got %b want 1", d[0]); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL write_timeout: busy never cleared"); end
    checks++; if (t_last - t_prev != 160) begin errors++; $display("FAIL write_scl_period: got %0t want 160", t_last - t_prev); end
    checks++; if (cap[8:0] !== {8'hA5, 1'b0}) begin errors++; $display("FAIL write_bits: got %b want 101001010", cap[8:0]); end
    ahb_read(32'h8, d);
    checks++; if ((d & NOIRQ) !== 32'h0000_0002) begin errors++; $display("FAIL write_status: got %h want 00000002", d); end
    checks++; if (starts - s0 != 1) begin errors++; $display("FAIL write_start: got %0d starts want 1", starts - s0); end
  endtask

`ifdef IIC_IRQ_EN
  task automatic test_irq();
    checks++; if (IIC_IRQ !== 1'b1) begin errors++; $display("FAIL irq_on_done: got %b want 1", IIC_IRQ); end
    ahb_write(32'h8, 32'h10);
    @(negedge HCLK);
    checks++; if (IIC_IRQ !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", IIC_IRQ); end
  endtask
`endif

  task automatic test_read();
    logic [31:0] d; bit ok; int p0;
    slv_ack_en = 1'b0; slv_byte = 8'h3C; base = nfall; slv_tx_en = 1'b1; p0 = stops;
    ahb_write(32'h0, 32'h1A);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL read_timeout: busy never cleared"); end
    checks++; if (cap[9:0] !== {8'h3C, 2'b10}) begin errors++; $display("FAIL read_bus: got %b want 0011110010", cap[9:0]); end
    checks++; if (stops - p0 != 1) begin errors++; $display("FAIL read_stop: got %0d stops want 1", stops - p0); end
    ahb_read(32'h8, d);
    checks++; if ((d & NOIRQ) !== 32'h0000_3C02) begin errors++; $display("FAIL read_status: got %h want 00003c02", d); end
    checks++; if ({IIC_SCL, sda} !== 2'b11) begin errors++; $display("FAIL read_bus_idle: got %b want 11", {IIC_SCL, sda}); end
    slv_tx_en = 1'b0;
  endtask

  task automatic test_arb();
    logic [31:0] d; bit ok;
    force_low = 1'b1;
    ahb_write(32'h0, 32'h01);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL arb_timeout: busy never cleared"); end
    ahb_read(32'h8, d);
    checks++; if ((d & NOIRQ) !== 32'h0000_3C08) begin errors++; $display("FAIL arb_status: got %h want 00003c08", d); end
    checks++; if (IIC_SCL !== 1'b1) begin errors++; $display("FAIL arb_scl: got %b want 1", IIC_SCL); end
`ifdef IIC_IRQ_EN
    checks++; if (IIC_IRQ !== 1'b1) begin errors++; $display("FAIL arb_irq: got %b want 1", IIC_IRQ); end
`endif
    force_low = 1'b0;
    @(negedge HCLK);
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL arb_sda_released: got %b want 1", sda); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; bit ok; int s0, p0;
    ahb_write(32'h4, 32'h5A);
    slv_ack_en = 1'b1; base = nfall + 1; s0 = starts; p0 = stops;
    ahb_write(32'h0, 32'h07);
    repeat (40) @(negedge HCLK);
    ahb_write(32'h0, 32'h09);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: busy never cleared"); end
    repeat (100) @(negedge HCLK);
    checks++; if (cap[9:0] !== {8'h5A, 2'b00}) begin errors++; $display("FAIL b2b_bits: got %b want 0101101000", cap[9:0]); end
    checks++; if (starts - s0 != 1 || stops - p0 != 1) begin errors++; $display("FAIL b2b_one_xfer: got %0d starts %0d stops want 1 1", starts - s0, stops - p0); end
    ahb_write(32'h8, 32'hFFFF_FFFF);
    ahb_read(32'h8, d);
    checks++; if (d !== 32'h0000_3C02) begin errors++; $display("FAIL b2b_status: got %h want 00003c02", d); end
    ahb_write(32'h0, 32'h10);
    ahb_read(32'h8, d);
    checks++; if (d !== 32'h0000_3C02) begin errors++; $display("FAIL noop_cmd_status: got %h want 00003c02", d); end
    slv_ack_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; int r0;
    ahb_write(32'h4, 32'h00);
    r0 = nrise;
    ahb_write(32'h0, 32'h05);
    for (int i = 0; i < 2000 && nrise < r0 + 5; i++) @(negedge HCLK);
    checks++; if (nrise < r0 + 5 || sda !== 1'b0) begin errors++; $display("FAIL mid_reach_bit4: rises=%0d sda=%b want %0d 0", nrise - r0, sda, 5); end
    HRESET = 1'b1;
    @(negedge HCLK);
    checks++; if ({IIC_SCL, sda} !== 2'b11) begin errors++; $display("FAIL mid_reset_bus: got %b want 11", {IIC_SCL, sda}); end
    HRESET = 1'b0;
    ahb_read(32'h8, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_status: got %h want 0", d); end
    ahb_read(32'hC, d);
    checks++; if (d !== 32'd124) begin errors++; $display("FAIL mid_reset_prescale: got %0d want 124", d); end
  endtask

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HSIZE = 3'b010;
    HPROT = 4'b0011; HWRITE = 1'b0; HWDATA = '0; HREADY = 1'b1;
    test_reset();
    test_write();
`ifdef IIC_IRQ_EN
    test_irq();
`endif
    test_read();
    test_arb();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
